global_ld_align: RTL and testbench

// - Read-data realignment stage directly downstream of the system XBAR R channel, upstream of the global LD/ST

---
 rtl/global_ld_align_pkg.sv | 49 ++++
 rtl/global_ld_align_ld_byte_stitch.sv | 25 ++
 rtl/global_ld_align.sv | 178 +++++++++++++++++
 tb/tb_global_ld_align.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/global_ld_align_pkg.sv
// Shared types and helpers for the global load realignment path.
// The beat-count helper is also used by the AR burst generator so that
// both sides agree on how many input beats a command will return.
package global_ld_align_pkg;

   localparam int unsigned DefAxiDataWidth = 512;
   localparam int unsigned DefBytesWidth   = 32;
   localparam int unsigned DefAxiIdWidth   = 4;
   localparam int unsigned DefAxiUserWidth = 4;
   localparam int unsigned DefBeatBytes    = DefAxiDataWidth / 8;
   localparam int unsigned DefOffW         = $clog2(DefBeatBytes);

   // Byte offset of an address inside one AXI beat.
   typedef logic [DefOffW-1:0] axi_byte_off_t;

   // System AXI R channel beat.
   typedef struct packed {
      logic [DefAxiDataWidth-1:0] data;
      logic [DefAxiIdWidth-1:0]   id;
      logic [1:0]                 resp;
      logic                       last;
      logic [DefAxiUserWidth-1:0] user;
   } ld_axi_r_t;

   // Realignment FSM states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PASS,
      ST_FIRST,
      ST_STREAM,
      ST_DRAIN
   } ld_align_state_e;

   // Number of beats covering [off, off+bytes) when each beat holds 2**off_w bytes.
   // Evaluated wide so that off+bytes cannot overflow for any BytesWidth up to 62.
   function automatic logic [63:0] beats_of(input logic [63:0] off,
                                            input logic [63:0] bytes,
                                            input int unsigned off_w);
      logic [63:0] sum;
      sum = off + bytes + ((64'd1 << off_w) - 64'd1);
      return sum >> off_w;
   endfunction

   // Larger AXI response wins, so SLVERR/DECERR are never hidden by OKAY.
   function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/global_ld_align_ld_byte_stitch.sv
// Two-beat byte funnel shifter: selects B consecutive bytes starting at
// byte off_i out of the concatenation {in_i, hold_i} (hold_i is the older beat).
module ld_byte_stitch #(
   parameter int unsigned AxiDataWidth = 512,
   localparam int unsigned B    = AxiDataWidth / 8,
   localparam int unsigned OffW = $clog2(B)
) (
   input  logic [OffW-1:0]         off_i,
   input  logic [AxiDataWidth-1:0] hold_i,
   input  logic [AxiDataWidth-1:0] in_i,
   output logic [AxiDataWidth-1:0] data_o
);

   genvar gi;
   generate
      for (gi = 0; gi < B; gi++) begin : g_lane
         // Source byte index into the 2B-byte window; the top bit picks the beat.
         logic [OffW:0] src;
         assign src = {1'b0, off_i} + (OffW+1)'(gi);
         assign data_o[gi*8 +: 8] = src[OffW] ? in_i[{src[OffW-1:0], 3'b000} +: 8]
                                              : hold_i[{src[OffW-1:0], 3'b000} +: 8];
      end
   endgenerate

endmodule

// File: rtl/global_ld_align.sv
// Read-data realignment stage behind the system XBAR R channel.
// Shifts the returned stream so the first requested byte lands in lane 0 of
// output beat 0, stitching consecutive input beats across burst boundaries.
module global_ld_align
   import global_ld_align_pkg::*;
#(
   parameter int unsigned AxiDataWidth = DefAxiDataWidth,
   parameter int unsigned BytesWidth   = DefBytesWidth,
   parameter type         axi_r_t      = ld_axi_r_t,
   localparam int unsigned B    = AxiDataWidth / 8,
   localparam int unsigned OffW = $clog2(B)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [OffW-1:0]       cmd_offset_i,
   input  logic [BytesWidth-1:0] cmd_bytes_i,
   input  logic                  r_valid_i,
   output logic                  r_ready_o,
   input  axi_r_t                r_i,
   output logic                  r_valid_o,
   input  logic                  r_ready_i,
   output axi_r_t                r_o
);

   localparam int unsigned CntW = BytesWidth + 1;

   ld_align_state_e state_reg, state_next;
   logic [CntW-1:0] in_rem_reg, in_rem_next;
   logic [CntW-1:0] out_rem_reg, out_rem_next;
   logic [OffW-1:0] off_reg, off_next;
   axi_r_t          hold_reg, hold_next;
   axi_r_t          r_o_reg, r_o_next;
   logic            r_valid_reg, r_valid_next;

   logic [CntW-1:0]         ni_calc;
   logic [CntW-1:0]         no_calc;
   logic                    slot_free;
   logic [AxiDataWidth-1:0] stitch_in;
   logic [AxiDataWidth-1:0] stitch_data;

   // Input and output beat counts for the incoming command; Ni is No or No+1.
   assign ni_calc = CntW'(beats_of(64'(cmd_offset_i), 64'(cmd_bytes_i), OffW));
   assign no_calc = CntW'(beats_of(64'd0, 64'(cmd_bytes_i), OffW));

   // The output register can take a new beat when empty or being emptied now.
   assign slot_free = !r_valid_reg || r_ready_i;

   // While draining there is no newer beat, so the upper lanes shift in zeros.
   assign stitch_in = (state_reg == ST_DRAIN) ? '0 : r_i.data;

   ld_byte_stitch #(
      .AxiDataWidth(AxiDataWidth)
   ) i_stitch (
      .off_i  (off_reg),
      .hold_i (hold_reg.data),
      .in_i   (stitch_in),
      .data_o (stitch_data)
   );

   // Next-state, counter, hold and output-register logic; handshakes decoded here.
   always_comb begin
      state_next   = state_reg;
      in_rem_next  = in_rem_reg;
      out_rem_next = out_rem_reg;
      off_next     = off_reg;
      hold_next    = hold_reg;
      r_o_next     = r_o_reg;
      r_valid_next = r_valid_reg;
      cmd_ready_o  = 1'b0;
      r_ready_o    = 1'b0;

      // A consumed output beat frees the register unless reloaded below.
      if (r_valid_reg && r_ready_i) begin
         r_valid_next = 1'b0;
      end

      case (state_reg)
         ST_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               off_next     = cmd_offset_i;
               in_rem_next  = ni_calc;
               out_rem_next = no_calc;
               if (cmd_bytes_i != '0) begin
                  state_next = (cmd_offset_i == '0) ? ST_PASS : ST_FIRST;
               end
            end
         end

         ST_PASS: begin
            r_ready_o = slot_free;
            if (r_valid_i && slot_free) begin
               r_o_next      = r_i;
               r_o_next.last = (out_rem_reg == CntW'(1));
               r_valid_next  = 1'b1;
               in_rem_next   = in_rem_reg - CntW'(1);
               out_rem_next  = out_rem_reg - CntW'(1);
               if (out_rem_reg == CntW'(1)) begin
                  state_next = ST_IDLE;
               end
            end
         end

         ST_FIRST: begin
            // First beat only primes the hold register; nothing is output yet.
            r_ready_o = 1'b1;
            if (r_valid_i) begin
               hold_next   = r_i;
               in_rem_next = in_rem_reg - CntW'(1);
               state_next  = (in_rem_reg == CntW'(1)) ? ST_DRAIN : ST_STREAM;
            end
         end

         ST_STREAM: begin
            r_ready_o = slot_free;
            if (r_valid_i && slot_free) begin
               r_o_next      = r_i;
               r_o_next.data = stitch_data;
               r_o_next.resp = resp_max(hold_reg.resp, r_i.resp);
               r_o_next.last = (out_rem_reg == CntW'(1));
               r_valid_next  = 1'b1;
               hold_next     = r_i;
               in_rem_next   = in_rem_reg - CntW'(1);
               out_rem_next  = out_rem_reg - CntW'(1);
               if (out_rem_reg == CntW'(1)) begin
                  state_next = ST_IDLE;
               end else if (in_rem_reg == CntW'(1)) begin
                  state_next = ST_DRAIN;
               end
            end
         end

         ST_DRAIN: begin
            // Last output is built from the held beat alone.
            if (slot_free) begin
               r_o_next      = hold_reg;
               r_o_next.data = stitch_data;
               r_o_next.last = 1'b1;
               r_valid_next  = 1'b1;
               in_rem_next   = '0;
               out_rem_next  = '0;
               state_next    = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg   <= ST_IDLE;
         in_rem_reg  <= '0;
         out_rem_reg <= '0;
         off_reg     <= '0;
         hold_reg    <= '0;
         r_o_reg     <= '0;
         r_valid_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         in_rem_reg  <= in_rem_next;
         out_rem_reg <= out_rem_next;
         off_reg     <= off_next;
         hold_reg    <= hold_next;
         r_o_reg     <= r_o_next;
         r_valid_reg <= r_valid_next;
      end
   end

   assign r_valid_o = r_valid_reg;
   assign r_o       = r_o_reg;

endmodule

// File: tb/tb_global_ld_align.sv
// Directed bench for global_ld_align (B=64): table of commands with
// hand-computed beat counts and responses, plus reset sequences.
module tb_global_ld_align;
   import global_ld_align_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [5:0]  cmd_offset_i = '0;
   logic [31:0] cmd_bytes_i = '0;
   logic        r_valid_i = 1'b0;
   logic        r_ready_o;
   ld_axi_r_t   r_i = '0;
   logic        r_valid_o;
   logic        r_ready_i = 1'b0;
   ld_axi_r_t   r_o;

   int checks = 0;
   int errors = 0;

   global_ld_align dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_offset_i (cmd_offset_i),
      .cmd_bytes_i  (cmd_bytes_i),
      .r_valid_i    (r_valid_i),
      .r_ready_o    (r_ready_o),
      .r_i          (r_i),
      .r_valid_o    (r_valid_o),
      .r_ready_i    (r_ready_i),
      .r_o          (r_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          off;
      int          bytes;
      int          ni;
      int          no;
      logic [15:0] in_resp;   // 2 bits per input beat
      logic [7:0]  in_last;   // r.last per input beat
      logic [15:0] exp_resp;  // 2 bits per output beat
      int          stall_at;
      int          stall_len;
      int          seed;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] mk_data(input int n, input int seed);
      logic [511:0] d;
      for (int k = 0; k < 64; k++) d[k*8 +: 8] = 8'((n*64 + k + seed) & 255);
      return d;
   endfunction

   // Expected output beat from the byte-stream view: stream byte s sits at
   // offset s-off of the output; bytes past the last input beat read as zero.
   function automatic logic [511:0] exp_data(input int off, input int o, input int ni, input int seed);
      logic [511:0] d;
      for (int j = 0; j < 64; j++) begin
         int s;
         s = off + 64*o + j;
         d[j*8 +: 8] = (s < ni*64) ? 8'((s + seed) & 255) : 8'h00;
      end
      return d;
   endfunction

   function automatic ld_axi_r_t mk_beat(input int n, input vec_t t);
      ld_axi_r_t b;
      b.data = mk_data(n, t.seed);
      b.id   = 4'(n + 1);
      b.resp = t.in_resp[2*n +: 2];
      b.last = t.in_last[n];
      b.user = 4'(n + 9);
      return b;
   endfunction

   task automatic run_vec(input int v);
      vec_t t;
      int   cyc, in_idx, out_idx, budget, exp_lat, src;
      int   in_cyc[8];
      bit   seen_valid, done;
      t = vecs[v];
      for (int i = 0; i < 8; i++) in_cyc[i] = -100;
      @(negedge clk_i);
      budget = 0;
      while (!cmd_ready_o && budget < 20) begin
         @(negedge clk_i);
         budget++;
      end
      chk($sformatf("v%0d_cmd_ready", v), 512'(cmd_ready_o), 512'(1));
      cyc = 0; in_idx = 0; out_idx = 0; seen_valid = 0; done = 0;
      while (cyc < 60 && !done) begin
         cmd_valid_i  = (cyc == 0);
         cmd_offset_i = 6'(t.off);
         cmd_bytes_i  = 32'(t.bytes);
         r_valid_i    = (in_idx < t.ni);
         r_i          = r_valid_i ? mk_beat(in_idx, t) : '0;
         r_ready_i    = !(cyc >= t.stall_at && cyc < t.stall_at + t.stall_len);
         #1;
         if (cyc == 0)
            chk($sformatf("v%0d_idle_no_accept", v), 512'(r_ready_o), 512'(0));
         if (!r_ready_i && r_valid_o)
            chk($sformatf("v%0d_stall_rdy_o", v), 512'(r_ready_o), 512'(0));
         if (r_valid_o && !seen_valid) begin
            seen_valid = 1;
            if (t.off == 0)      exp_lat = in_cyc[0] + 1;
            else if (t.ni == 1)  exp_lat = in_cyc[0] + 2;
            else                 exp_lat = in_cyc[1] + 1;
            chk($sformatf("v%0d_latency", v), 512'(cyc), 512'(exp_lat));
         end
         if (r_valid_o && r_ready_i) begin
            if (out_idx >= t.no) begin
               chk($sformatf("v%0d_extra_beat", v), 512'(out_idx + 1), 512'(t.no));
            end else begin
               src = out_idx + ((t.off != 0) ? 1 : 0);
               if (src > t.ni - 1) src = t.ni - 1;
               chk($sformatf("v%0d_o%0d_data", v, out_idx), r_o.data, exp_data(t.off, out_idx, t.ni, t.seed));
               chk($sformatf("v%0d_o%0d_last", v, out_idx), 512'(r_o.last), 512'(out_idx == t.no - 1));
               chk($sformatf("v%0d_o%0d_resp", v, out_idx), 512'(r_o.resp), 512'(t.exp_resp[2*out_idx +: 2]));
               chk($sformatf("v%0d_o%0d_id", v, out_idx), 512'(r_o.id), 512'(src + 1));
            end
            out_idx++;
         end
         if (r_valid_i && r_ready_o) begin
            in_cyc[in_idx] = cyc;
            in_idx++;
         end
         @(negedge clk_i);
         cyc++;
         done = (in_idx == t.ni) && (out_idx == t.no);
      end
      cmd_valid_i = 1'b0;
      r_valid_i   = 1'b0;
      r_ready_i   = 1'b1;
      chk($sformatf("v%0d_complete", v), 512'(done), 512'(1));
      chk($sformatf("v%0d_in_beats", v), 512'(in_idx), 512'(t.ni));
      #1;
      chk($sformatf("v%0d_back_idle", v), 512'(cmd_ready_o), 512'(1));
   endtask

   initial begin
      //           off bytes ni no in_resp   in_last  exp_resp stall_at len seed
      vecs[0] = '{0,   128,  2, 2, 16'h0000, 8'h02, 16'h0000, 1000, 0,  0};
      vecs[1] = '{8,   120,  2, 2, 16'h0000, 8'h02, 16'h0000, 1000, 0,  17};
      vecs[2] = '{8,   64,   2, 1, 16'h0000, 8'h02, 16'h0000, 1000, 0,  33};
      vecs[3] = '{16,  200,  4, 4, 16'h0008, 8'h0A, 16'h000A, 4,    3,  51};
      vecs[4] = '{5,   0,    0, 0, 16'h0000, 8'h00, 16'h0000, 1000, 0,  0};
      vecs[5] = '{63,  1,    1, 1, 16'h0002, 8'h01, 16'h0002, 1000, 0,  77};
      vecs[6] = '{0,   1,    1, 1, 16'h0003, 8'h01, 16'h0003, 1000, 0,  90};
      vecs[7] = '{63,  66,   3, 2, 16'h0031, 8'h04, 16'h000D, 1000, 0,  101};
      vecs[8] = '{4,   256,  5, 4, 16'h0200, 8'h10, 16'h0080, 1000, 0,  123};

      // Reset state.
      rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_valid", 512'(r_valid_o), 512'(0));
      chk("rst_r_o", 512'(r_o), 512'(0));
      rst_ni = 1'b1;
      r_valid_i = 1'b1;
      r_i = mk_beat(0, vecs[0]);
      @(negedge clk_i);
      #1;
      chk("rst_cmd_ready", 512'(cmd_ready_o), 512'(1));
      chk("rst_r_ready", 512'(r_ready_o), 512'(0));
      chk("rst_valid_after", 512'(r_valid_o), 512'(0));
      r_valid_i = 1'b0;
      r_ready_i = 1'b1;

      for (int v = 0; v < 9; v++) run_vec(v);

      // Reset in the middle of a STREAM command: off=8, bytes=200 (Ni=No=4).
      @(negedge clk_i);
      cmd_valid_i = 1'b1; cmd_offset_i = 6'd8; cmd_bytes_i = 32'd200;
      @(negedge clk_i);
      cmd_valid_i = 1'b0; r_valid_i = 1'b1; r_i = mk_beat(0, vecs[1]);
      @(negedge clk_i);
      r_i = mk_beat(1, vecs[1]);
      @(negedge clk_i);
      #1;
      chk("mid_valid_before_rst", 512'(r_valid_o), 512'(1));
      r_i = mk_beat(2, vecs[1]);
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      chk("mid_rst_valid", 512'(r_valid_o), 512'(0));
      chk("mid_rst_r_ready", 512'(r_ready_o), 512'(0));
      chk("mid_rst_cmd_ready", 512'(cmd_ready_o), 512'(1));
      r_valid_i = 1'b0;
      r_i = '0;
      run_vec(3);
      run_vec(7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
